nco_clk_gen: RTL and testbench

NCO_CLK_GEN -- requirements
Module: nco_clk_gen

---
 rtl/nco_pkg.sv | 23 ++
 rtl/nco_channel.sv | 88 ++++++++
 rtl/nco_clk_gen.sv | 52 +++++
 tb/tb_nco_clk_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared constants and helpers for the NCO clock generator.
// Pure definitions: no logic, no latency, no flow control.
package nco_pkg;

  localparam int NCH_MAX   = 16;
  localparam int ACC_W_MAX = 48;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reset step: quarter turn of the accumulator (f_clk/4).
  function automatic logic [ACC_W_MAX-1:0] def_step(input int acc_w);
    return ACC_W_MAX'(1) << (acc_w - 2);
  endfunction

  // Reset duty: half turn (50 % duty).
  function automatic logic [ACC_W_MAX-1:0] def_duty(input int acc_w);
    return ACC_W_MAX'(1) << (acc_w - 1);
  endfunction

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: accumulator, shadow/active step+duty, compare and wrap tick; outputs registered (1 cycle).
// No backpressure; retunes are held pending until a wrap or disable. Optional offset via NCO_PHASE_OFS_EN.
module nco_channel
  import nco_pkg::*;
#(
  parameter int               ACC_W    = 32,
  parameter logic [ACC_W-1:0] DEF_STEP = ACC_W'(def_step(ACC_W)),
  parameter logic [ACC_W-1:0] DEF_DUTY = ACC_W'(def_duty(ACC_W))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [ACC_W-1:0] cfg_step,
  input  logic [ACC_W-1:0] cfg_duty,
`ifdef NCO_PHASE_OFS_EN
  input  logic [ACC_W-1:0] cfg_ofs,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] step_act, duty_act;
  logic [ACC_W-1:0] step_sh, duty_sh;
  logic [ACC_W-1:0] clr_val;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             apply;

  assign sum   = {1'b0, acc} + {1'b0, step_act};
  assign carry = en & sum[ACC_W] & ~sync_clr;
  // A write landing on the apply edge wins: it stays pending for the next wrap.
  assign apply = pend & ~wr & (carry | ~en);

`ifdef NCO_PHASE_OFS_EN
  logic [ACC_W-1:0] ofs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ofs <= '0;
    else if (wr) ofs <= cfg_ofs;
  end

  assign clr_val = ofs;
`else
  assign clr_val = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_sh  <= DEF_STEP;
      duty_sh  <= DEF_DUTY;
      step_act <= DEF_STEP;
      duty_act <= DEF_DUTY;
      pend     <= 1'b0;
    end else if (wr) begin
      step_sh <= cfg_step;
      duty_sh <= cfg_duty;
      pend    <= 1'b1;
    end else if (apply) begin
      step_act <= step_sh;
      duty_act <= duty_sh;
      pend     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (sync_clr) begin
      acc     <= clr_val;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (en) begin
      acc     <= sum[ACC_W-1:0];
      clk_out <= (sum[ACC_W-1:0] >= duty_act);
      tick    <= carry;
    end else begin
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/nco_clk_gen.sv
// Multi-channel NCO clock divider: decodes config writes per channel, fans out sync_clr; outputs registered (1 cycle).
// No backpressure. Macro NCO_PHASE_OFS_EN adds cfg_ofs, the per-channel phase loaded by sync_clr.
module nco_clk_gen
  import nco_pkg::*;
#(
  parameter int               NCH      = 4,
  parameter int               ACC_W    = 32,
  parameter logic [ACC_W-1:0] DEF_STEP = ACC_W'(def_step(ACC_W)),
  parameter logic [ACC_W-1:0] DEF_DUTY = ACC_W'(def_duty(ACC_W))
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         en,
  input  logic                   sync_clr,
  input  logic                   cfg_wr,
  input  logic [ch_w(NCH)-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]       cfg_step,
  input  logic [ACC_W-1:0]       cfg_duty,
`ifdef NCO_PHASE_OFS_EN
  input  logic [ACC_W-1:0]       cfg_ofs,
`endif
  output logic [NCH-1:0]         clk_out,
  output logic [NCH-1:0]         tick,
  output logic [NCH-1:0]         cfg_pend
);

  localparam int CH_W = ch_w(NCH);

  // Selects beyond NCH-1 match no channel, so those writes drop silently.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    nco_channel #(
      .ACC_W    (ACC_W),
      .DEF_STEP (DEF_STEP),
      .DEF_DUTY (DEF_DUTY)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[i]),
      .sync_clr (sync_clr),
      .wr       (cfg_wr && (cfg_ch == CH_W'(i))),
      .cfg_step (cfg_step),
      .cfg_duty (cfg_duty),
`ifdef NCO_PHASE_OFS_EN
      .cfg_ofs  (cfg_ofs),
`endif
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .pend     (cfg_pend[i])
    );
  end

endmodule

// File: tb/tb_nco_clk_gen.sv
// Directed bench for nco_clk_gen (3 channels so an out-of-range cfg_ch is expressible).
module tb_nco_clk_gen;

  localparam int NCH   = 3;
  localparam int ACC_W = 32;
  localparam logic [31:0] Q = 32'h4000_0000;
  localparam logic [31:0] H = 32'h8000_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   en;
  logic             sync_clr;
  logic             cfg_wr;
  logic [1:0]       cfg_ch;
  logic [ACC_W-1:0] cfg_step;
  logic [ACC_W-1:0] cfg_duty;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   cfg_pend;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nco_clk_gen #(.NCH(NCH), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_step (cfg_step),
    .cfg_duty (cfg_duty),
`ifdef NCO_PHASE_OFS_EN
    .cfg_ofs  ('0),
`endif
    .clk_out  (clk_out),
    .tick     (tick),
    .cfg_pend (cfg_pend)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] e;
    rst_n = 1'b0; en = '0; sync_clr = 1'b0; cfg_wr = 1'b0;
    cfg_ch = '0; cfg_step = '0; cfg_duty = '0;
    repeat (3) cyc();
    chk("rst_clk_out", 64'(clk_out), 64'h0);
    chk("rst_tick", 64'(tick), 64'h0);
    chk("rst_pend", 64'(cfg_pend), 64'h0);
    chk("rst_acc0", 64'(dut.g_ch[0].u_ch.acc), 64'h0);

    // Defaults: quarter-turn step, half duty -> 0,1,1,0 with tick every 4th
    rst_n = 1'b1; en = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      e = 32'(k) * Q;
      chk("def_acc0", 64'(dut.g_ch[0].u_ch.acc), 64'(e));
      chk("def_clk_out", 64'(clk_out), (e >= H) ? 64'h7 : 64'h0);
      chk("def_tick", 64'(tick), (k % 4 == 0) ? 64'h7 : 64'h0);
    end

    // Retune ch1 mid-period: pending until wrap, then period 8
    cyc();
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_step = 32'h2000_0000; cfg_duty = H;
    cyc();
    cfg_wr = 1'b0;
    chk("rt_pend_a", 64'(cfg_pend), 64'h2);
    chk("rt_acc1_a", 64'(dut.g_ch[1].u_ch.acc), 64'h8000_0000);
    cyc();
    chk("rt_pend_b", 64'(cfg_pend), 64'h2);
    chk("rt_clk1_b", 64'(clk_out[1]), 64'h1);
    cyc();
    chk("rt_pend_wrap", 64'(cfg_pend), 64'h0);
    chk("rt_tick1_wrap", 64'(tick[1]), 64'h1);
    chk("rt_clk1_wrap", 64'(clk_out[1]), 64'h0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      e = 32'(k) * 32'h2000_0000;
      chk("rt_acc1", 64'(dut.g_ch[1].u_ch.acc), 64'(e));
      chk("rt_clk1", 64'(clk_out[1]), (e >= H) ? 64'h1 : 64'h0);
      chk("rt_tick1", 64'(tick[1]), (k == 8) ? 64'h1 : 64'h0);
    end

    // Write on ch0's carry edge: stays pending for one more wrap
    repeat (3) cyc();
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_step = H; cfg_duty = H;
    cyc();
    cfg_wr = 1'b0;
    chk("cw_tick0", 64'(tick[0]), 64'h1);
    chk("cw_pend", 64'(cfg_pend), 64'h1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("cw_pend_hold", 64'(cfg_pend[0]), 64'h1);
      chk("cw_acc0_old", 64'(dut.g_ch[0].u_ch.acc), 64'(32'(k) * Q));
    end
    cyc();
    chk("cw_tick0_apply", 64'(tick[0]), 64'h1);
    chk("cw_pend_apply", 64'(cfg_pend), 64'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("cw_acc0_new", 64'(dut.g_ch[0].u_ch.acc), (k % 2 == 1) ? 64'h8000_0000 : 64'h0);
      chk("cw_tick0_new", 64'(tick[0]), (k % 2 == 0) ? 64'h1 : 64'h0);
    end

    // sync_clr with channels at different phases (ch0 would carry this edge)
    cyc();
    chk("sc_acc1_pre", 64'(dut.g_ch[1].u_ch.acc), 64'hA000_0000);
    sync_clr = 1'b1;
    cyc();
    sync_clr = 1'b0;
    chk("sc_clk_out", 64'(clk_out), 64'h0);
    chk("sc_tick", 64'(tick), 64'h0);
    chk("sc_acc0", 64'(dut.g_ch[0].u_ch.acc), 64'h0);
    chk("sc_acc1", 64'(dut.g_ch[1].u_ch.acc), 64'h0);
    chk("sc_acc2", 64'(dut.g_ch[2].u_ch.acc), 64'h0);
    cyc();
    chk("sc_acc0_1", 64'(dut.g_ch[0].u_ch.acc), 64'h8000_0000);
    chk("sc_acc1_1", 64'(dut.g_ch[1].u_ch.acc), 64'h2000_0000);
    chk("sc_acc2_1", 64'(dut.g_ch[2].u_ch.acc), 64'(Q));
    chk("sc_clk_out_1", 64'(clk_out), 64'h1);

    // Disable ch2 for 5 cycles; write to cfg_ch=NCH is dropped
    en = 3'b011; cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_step = 32'h1234_5678; cfg_duty = '0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 1) begin
        cfg_wr = 1'b0;
        chk("dis_pend_oor", 64'(cfg_pend), 64'h0);
      end
      chk("dis_clk2", 64'(clk_out[2]), 64'h0);
      chk("dis_tick2", 64'(tick[2]), 64'h0);
      chk("dis_acc2", 64'(dut.g_ch[2].u_ch.acc), 64'(Q));
    end
    en = 3'b111;
    cyc();
    chk("res_acc2_a", 64'(dut.g_ch[2].u_ch.acc), 64'h8000_0000);
    chk("res_clk2_a", 64'(clk_out[2]), 64'h1);
    cyc();
    chk("res_acc2_b", 64'(dut.g_ch[2].u_ch.acc), 64'hC000_0000);
    cyc();
    chk("res_acc2_c", 64'(dut.g_ch[2].u_ch.acc), 64'h0);
    chk("res_tick2_c", 64'(tick[2]), 64'h1);

    // Reset mid-retune: pending dropped, defaults back on all channels
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_step = 32'h1000_0000; cfg_duty = H;
    cyc();
    cfg_wr = 1'b0;
    chk("mr_pend1", 64'(cfg_pend[1]), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_clk_out", 64'(clk_out), 64'h0);
    chk("mr_tick", 64'(tick), 64'h0);
    chk("mr_pend", 64'(cfg_pend), 64'h0);
    chk("mr_acc1", 64'(dut.g_ch[1].u_ch.acc), 64'h0);
    cyc();
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      e = 32'(k) * Q;
      chk("mr_acc1_def", 64'(dut.g_ch[1].u_ch.acc), 64'(e));
      chk("mr_clk_out_def", 64'(clk_out), (e >= H) ? 64'h7 : 64'h0);
      chk("mr_tick_def", 64'(tick), (k == 4) ? 64'h7 : 64'h0);
    end

    // Step 0 / duty 0 on ch2, applied while disabled: frozen, clk_out high
    en = 3'b011; cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_step = '0; cfg_duty = '0;
    cyc();
    cfg_wr = 1'b0;
    chk("z_pend_set", 64'(cfg_pend), 64'h4);
    cyc();
    chk("z_pend_apply", 64'(cfg_pend), 64'h0);
    en = 3'b111;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("z_clk2", 64'(clk_out[2]), 64'h1);
      chk("z_tick2", 64'(tick[2]), 64'h0);
      chk("z_acc2", 64'(dut.g_ch[2].u_ch.acc), 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
